// File: rtl/xor3_exerciser.sv
// -----------------------------------------------------------------------------
// xor3_exerciser
//
// Self-test stage for a 3-input combinational gate. The block steps the gate
// inputs {x0,x1,x2} through vectors 0..7. Each vector is held for DWELL
// cycles. The gate output z0 is sampled SETTLE cycles after the vector is
// applied and is compared against EXPECT[vector]. The block then reports
// pass/fail, a saturating mismatch count and the first failing vector.
//
// Parameters
//   DWELL   cycles each vector is held (>= 2)
//   SETTLE  cycles from vector application to the z0 sample (1..DWELL-1)
//   EXPECT  expected z0 per vector, bit k <-> vector k (default XOR3)
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      begin a run (sampled on the rising edge; ignored while busy)
//   z0         gate-under-test output, combinational from x0..x2
//   x0,x1,x2   registered gate inputs; vector k = {x0,x1,x2}, x0 is the MSB
//   busy       run in progress
//   done       run complete (level); a 1-cycle pulse per pass in loop builds
//   pass       done with zero mismatches
//   err_cnt    mismatch count, saturating at 15
//   fail_vec   first mismatching vector since the last start (0 if none)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE) for checkers
//
// Build option
//   XOR3_EXERCISER_LOOP_EN  when defined, the block runs passes continuously.
//                           After vector 7 it wraps to vector 0. done pulses
//                           for one cycle per pass, pass is refreshed each
//                           pass, and err_cnt accumulates across passes.
//                           Only rst stops the loop.
//
// Handshake: start is a request that is accepted on any rising edge where the
// block is in IDLE or DONE and rst is low. busy is high from the accepting
// edge until the run completes. The result (pass/err_cnt/fail_vec) is valid
// whenever done is high. rst has priority over start on the same edge.
// -----------------------------------------------------------------------------
module xor3_exerciser #(
  parameter int         DWELL  = 6,
  parameter int         SETTLE = 2,
  parameter logic [7:0] EXPECT = 8'b1001_0110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       z0,
  output logic       x0,
  output logic       x1,
  output logic       x2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_vec,
  output logic [1:0] state_dbg
);

  // Dwell counter width; at least one bit so a DWELL of 2 still has a counter.
  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

  // cnt_q holds 0 during the first cycle after a vector is applied. The edge
  // that ends the vector therefore sees cnt_q == DWELL-1. The sample edge is
  // SETTLE edges after the vector edge, which is where cnt_q == SETTLE-1. This
  // makes vector k sampled at edge T0 + k*DWELL + SETTLE.
  localparam logic [CW-1:0] CNT_LAST   = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_SAMPLE = CW'(SETTLE - 1);
  localparam logic [3:0]    ERR_MAX    = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic [2:0]    vec_q,      vec_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [3:0]    err_cnt_q,  err_cnt_d;
  logic [2:0]    fail_vec_q, fail_vec_d;
  logic          pass_q,     pass_d;
  logic          done_q,     done_d;

  // Datapath decode
  logic sample_now;
  logic mismatch;
  logic vec_last;
  logic pass_end;

  always_comb begin
    sample_now = (state_q == S_RUN) && (cnt_q == CNT_SAMPLE);
    mismatch   = sample_now && (z0 != EXPECT[vec_q]);
    vec_last   = (cnt_q == CNT_LAST);
    pass_end   = (state_q == S_RUN) && vec_last && (vec_q == 3'd7);
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          vec_d      = 3'd0;
          cnt_d      = '0;
          err_cnt_d  = 4'd0;
          fail_vec_d = 3'd0;
          pass_d     = 1'b0;
        end
      end

      S_RUN: begin
        if (vec_last) begin
          cnt_d = '0;
          if (vec_q == 3'd7) begin
            // The sample edge always falls before the last dwell edge.
            // So err_cnt_q is already final for this pass here.
            pass_d = (err_cnt_q == 4'd0);
            vec_d  = 3'd0;
`ifdef XOR3_EXERCISER_LOOP_EN
            state_d = S_RUN;
`else
            state_d = S_DONE;
`endif
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end

        if (mismatch) begin
          if (err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
          // err_cnt only clears on start and never wraps.
          // So a zero count marks the first failure since start.
          if (err_cnt_q == 4'd0) begin
            fail_vec_d = vec_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        vec_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // done: a level while parked in DONE, or a single-cycle pulse per pass in
  // the looping build.
  always_comb begin
`ifdef XOR3_EXERCISER_LOOP_EN
    done_d = pass_end;
`else
    done_d = (state_d == S_DONE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= 3'd0;
      cnt_q      <= '0;
      err_cnt_q  <= 4'd0;
      fail_vec_q <= 3'd0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  // vec_q is forced to 0 outside RUN, so it can drive the gate directly
  // without a combinational mux on the x outputs.
  assign x0        = vec_q[2];
  assign x1        = vec_q[1];
  assign x2        = vec_q[0];
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_vec  = fail_vec_q;
  assign state_dbg = state_q;

endmodule
